toy_bpu_btb_mem: RTL and testbench
==================================

# toy_bpu_btb_mem

Storage-side responder for the BTB entry memory request interface: holds the per-way BTB entry arrays and the per-set PLRU node array. It services the `mem_req_*` stream issued by the BPU BTB front end and returns `mem_ack_rdata` one cycle later. After reset it runs a self-initialisation walk that clears every set, so that all BTB ways come up invalid. It replaces the behavioural memory model behind the BTB in simulation and is the synthesis stand-in for the BTB SRAM macro.

## Interface
- Parameters:
  - `BTB_WAY_NUM`, default 4: number of ways; power of 2, at least 2.
  - `BTB_INDEX_WIDTH`, default 8: set index width, giving 2^BTB_INDEX_WIDTH sets.
  - `ENTRY_DATA_WIDTH`, default `BTB_TAG_WIDTH+ADDR_WIDTH+BPU_OFFSET_WIDTH+3`: bits per way entry. Bit [ENTRY_DATA_WIDTH-1] is the valid bit.
- Ports (one clock `clk`; reset `rst` is synchronous and active-high):
  - `clk` in 1: clock.
  - `rst` in 1: synchronous reset, active-high.
  - `mem_req_vld` in 1: request strobe.
  - `mem_req_wren` in BTB_WAY_NUM: per-way write enable. All zero means read.
  - `mem_req_addr` in BTB_INDEX_WIDTH: set index.
  - `mem_req_wdata` in `btb_entry_pkg`: write data, made of `entry_way[BTB_WAY_NUM]` plus `plru_node[BTB_WAY_NUM-2:0]`.
  - `mem_ack_rdata` out `btb_entry_pkg`: read data for all ways and the node of the requested set.
  - `mem_ack_vld` out 1: `mem_ack_rdata` is valid this cycle.
  - `init_done` out 1: high once the initialisation walk has finished; requests are accepted only while it is high.

## Operation
- FSM states:
  - INIT: entered on reset. `init_cnt` steps from 0 to 2^BTB_INDEX_WIDTH-1, one set per cycle. Each step writes all-zero data to every way and to the node of that set. On the last count, the FSM moves to READY.
  - READY: normal service. The FSM stays here until the next reset.
- Request acceptance:
  - A request is accepted when `mem_req_vld && init_done`.
  - A request presented during INIT is dropped: no ack and no write. Initiators must gate on `init_done`.
- Read (accepted request with wren == 0):
  - Every way and the node of set `mem_req_addr` appear on `mem_ack_rdata` in the next cycle.
  - `mem_ack_vld` is 1 in that cycle.
- Write (accepted request with wren != 0):
  - For each i with wren[i] set, `entry_way[i]` is written into way i.
  - The node array is written with `plru_node` whenever |wren is true.
  - The access still acknowledges next cycle. Read data is write-first: written ways and the node return the new data, unwritten ways return stored contents.
- Back-to-back accesses:
  - One request per cycle, with no bubbles.
  - A read in cycle N+1 to a set written in cycle N returns the cycle-N data. No hazard stall.
- Ack hold: when no request was accepted in the previous cycle, `mem_ack_vld` is 0 and `mem_ack_rdata` holds its last value.
- Out-of-range width: none. The address covers the full array, and `init_cnt` wraps only at INIT exit.

## Timing
- Reset values:
  - `mem_ack_rdata` = 0, `mem_ack_vld` = 0, `init_done` = 0.
  - FSM = INIT, `init_cnt` = 0.
- Init duration: `init_done` rises at the end of cycle 2^BTB_INDEX_WIDTH after reset deasserts, i.e. 256 cycles at the default.
- Read/write latency: 1 cycle, from request edge to ack edge.
- Reset mid-operation:
  - An ack pending in the reset cycle is discarded, and outputs return to their reset values.
  - The FSM restarts INIT at set 0. Array contents are fully re-cleared.
- Reset asserted during INIT: `init_cnt` returns to 0.

## Structure
- Shared in `toy_pack`:
  - `btb_entry_pkg`, including its `plru_node` field.
  - `BTB_WAY_NUM`, `BTB_INDEX_WIDTH`, `BTB_TAG_WIDTH`, `BPU_OFFSET_WIDTH`.
  - `ENTRY_DATA_WIDTH` as a package localparam, so that initiator and responder agree.
- One sub-module, `toy_bpu_btb_mem_bank`: a single-port registered-read array of depth 2^ADDR_WIDTH × DATA_WIDTH with write-first read.
  - It is instantiated BTB_WAY_NUM times for the ways and once for the node array.
  - The top level holds the INIT FSM and counter, muxes the init writes, and registers `mem_ack_vld`.

## Test plan
- **Init:** release reset, then present a read to set 0x00 at cycle 100. Required: no ack, and `init_done` = 0. Then `init_done` = 1 at cycle 256, and a read of set 0xFF acks with all ways and the node equal to 0.
- **Write then read:** write set 0x12 with wren = 4'b0101, way0 = 0xA5…, way2 = 0x3C…, node = 3'b101. Next cycle, read 0x12. Required: way0/way2 match the written data, way1/way3 = 0, node = 3'b101, `mem_ack_vld` = 1.
- **Partial write:** write set 0x12 with wren = 4'b0010. Required: the ack shows way1 as new data and way0/way2 preserved (write-first on the written way only), and the node is overwritten.
- **Back-to-back:** write 0x40 and read 0x40 in consecutive cycles, then leave one idle cycle. Required: the read acks the new data, and in the idle cycle `mem_ack_vld` = 0 with `mem_ack_rdata` unchanged.
- **Reset mid-stream:** write 0x07, then assert `rst` in the cycle its ack would appear. Required: `mem_ack_vld` = 0 and `init_done` = 0; after 256 cycles a read of 0x07 returns all zeros.
- **Random streaming:** 10k random requests after init, checked against a scoreboard model. Required: every ack is exactly 1 cycle after its request and matches the model.

Source files
------------

// File: rtl/toy_pack.sv
// Shared BTB geometry, entry payload and memory-responder state encoding.
package toy_pack;

    localparam int unsigned BTB_WAY_NUM      = 4;
    localparam int unsigned BTB_INDEX_WIDTH  = 8;
    localparam int unsigned BTB_TAG_WIDTH    = 10;
    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned BPU_OFFSET_WIDTH = 2;

    // Tag + target + offset + type/valid bits; MSB is the valid bit.
    localparam int unsigned ENTRY_DATA_WIDTH = BTB_TAG_WIDTH + ADDR_WIDTH + BPU_OFFSET_WIDTH + 3;

    // Tree PLRU needs one node bit per internal node of the way tree.
    localparam int unsigned PLRU_NODE_WIDTH  = BTB_WAY_NUM - 1;

    // Full set payload: every way entry plus the set's PLRU nodes.
    typedef struct packed {
        logic [BTB_WAY_NUM-1:0][ENTRY_DATA_WIDTH-1:0] entry_way;
        logic [BTB_WAY_NUM-2:0]                       plru_node;
    } btb_entry_pkg;

    typedef enum logic {
        BTB_MEM_INIT  = 1'b0,
        BTB_MEM_READY = 1'b1
    } btb_mem_state_e;

endpackage

// File: rtl/toy_bpu_btb_mem_bank.sv
// Single-port array with registered, write-first read data.
// rdata holds its last value on cycles without an access.
module toy_bpu_btb_mem_bank #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are not reset, the owner clears them explicitly.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: new data on a write, stored data on a read, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/toy_bpu_btb_mem.sv
// BTB entry memory responder: per-way entry banks plus a PLRU node bank,
// cleared by a one-set-per-cycle walk after reset, then serving one
// request per cycle with a one-cycle registered acknowledge.
module toy_bpu_btb_mem
    import toy_pack::btb_entry_pkg;
    import toy_pack::btb_mem_state_e;
    import toy_pack::BTB_MEM_INIT;
    import toy_pack::BTB_MEM_READY;
#(
    parameter int unsigned BTB_WAY_NUM      = toy_pack::BTB_WAY_NUM,
    parameter int unsigned BTB_INDEX_WIDTH  = toy_pack::BTB_INDEX_WIDTH,
    parameter int unsigned ENTRY_DATA_WIDTH = toy_pack::ENTRY_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_req_vld,
    input  logic [BTB_WAY_NUM-1:0]     mem_req_wren,
    input  logic [BTB_INDEX_WIDTH-1:0] mem_req_addr,
    input  btb_entry_pkg               mem_req_wdata,
    output btb_entry_pkg               mem_ack_rdata,
    output logic                       mem_ack_vld,
    output logic                       init_done
);

    localparam int unsigned NODE_WIDTH = BTB_WAY_NUM - 1;
    localparam logic [BTB_INDEX_WIDTH-1:0] INIT_LAST = {BTB_INDEX_WIDTH{1'b1}};

    btb_mem_state_e state;
    btb_mem_state_e state_nxt;

    logic [BTB_INDEX_WIDTH-1:0] init_cnt;
    logic [BTB_INDEX_WIDTH-1:0] init_cnt_nxt;

    logic                                         req_acc_c;
    logic                                         bank_en;
    logic [BTB_INDEX_WIDTH-1:0]                   bank_addr;
    logic [BTB_WAY_NUM-1:0]                       way_we;
    logic [BTB_WAY_NUM-1:0][ENTRY_DATA_WIDTH-1:0] way_wdata;
    logic [BTB_WAY_NUM-1:0][ENTRY_DATA_WIDTH-1:0] way_rdata;
    logic                                         node_we;
    logic [NODE_WIDTH-1:0]                        node_wdata;
    logic [NODE_WIDTH-1:0]                        node_rdata;

    // Requests are only honoured once the clear walk has finished.
    assign req_acc_c = mem_req_vld && init_done;

    // State, init counter and status/ack registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BTB_MEM_INIT;
            init_cnt    <= '0;
            init_done   <= 1'b0;
            mem_ack_vld <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init_cnt_nxt;
            init_done   <= (state_nxt == BTB_MEM_READY);
            mem_ack_vld <= req_acc_c;
        end
    end

    // Next state and bank port mux: clear walk in INIT, request path in READY.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        bank_en      = 1'b0;
        bank_addr    = mem_req_addr;
        way_we       = '0;
        way_wdata    = mem_req_wdata.entry_way;
        node_we      = 1'b0;
        node_wdata   = mem_req_wdata.plru_node;

        case (state)
            BTB_MEM_INIT: begin
                bank_en      = 1'b1;
                bank_addr    = init_cnt;
                way_we       = '1;
                way_wdata    = '0;
                node_we      = 1'b1;
                node_wdata   = '0;
                init_cnt_nxt = BTB_INDEX_WIDTH'(init_cnt + 1'b1);
                if (init_cnt == INIT_LAST) begin
                    state_nxt = BTB_MEM_READY;
                end
            end
            BTB_MEM_READY: begin
                bank_en = req_acc_c;
                way_we  = mem_req_wren;
                node_we = |mem_req_wren;
            end
            default: begin
                state_nxt    = BTB_MEM_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    // One bank per way.
    for (genvar i = 0; i < BTB_WAY_NUM; i++) begin : g_way
        toy_bpu_btb_mem_bank #(
            .ADDR_WIDTH (BTB_INDEX_WIDTH),
            .DATA_WIDTH (ENTRY_DATA_WIDTH)
        ) u_way_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (bank_en),
            .we    (way_we[i]),
            .addr  (bank_addr),
            .wdata (way_wdata[i]),
            .rdata (way_rdata[i])
        );
    end

    // PLRU node bank, written whenever any way of the set is written.
    toy_bpu_btb_mem_bank #(
        .ADDR_WIDTH (BTB_INDEX_WIDTH),
        .DATA_WIDTH (NODE_WIDTH)
    ) u_node_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (bank_en),
        .we    (node_we),
        .addr  (bank_addr),
        .wdata (node_wdata),
        .rdata (node_rdata)
    );

    // Bank read registers form the ack payload directly.
    assign mem_ack_rdata = {way_rdata, node_rdata};

endmodule

// File: tb/tb_toy_bpu_btb_mem.sv
// Directed and random-stream bench for the BTB entry memory responder.
module tb_toy_bpu_btb_mem;
    import toy_pack::*;

    localparam int unsigned W  = ENTRY_DATA_WIDTH;
    localparam int unsigned NW = BTB_WAY_NUM;
    localparam int unsigned IW = BTB_INDEX_WIDTH;
    localparam int unsigned NS = 2 ** IW;

    localparam logic [W-1:0] W0 = 47'h25A5_A5A5_A5A5;
    localparam logic [W-1:0] W1 = 47'h7123_4567_89AB;
    localparam logic [W-1:0] W2 = 47'h3C3C_3C3C_3C3C;
    localparam logic [W-1:0] W3 = 47'h5A5A_5A5A_5A5A;
    localparam logic [W-1:0] JK = 47'h1111_2222_3333;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req_vld;
    logic [NW-1:0] mem_req_wren;
    logic [IW-1:0] mem_req_addr;
    btb_entry_pkg  mem_req_wdata;
    btb_entry_pkg  mem_ack_rdata;
    logic          mem_ack_vld;
    logic          init_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    toy_bpu_btb_mem dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_vld   (mem_req_vld),
        .mem_req_wren  (mem_req_wren),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_ack_rdata (mem_ack_rdata),
        .mem_ack_vld   (mem_ack_vld),
        .init_done     (init_done)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic btb_entry_pkg mk(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                        input logic [W-1:0] w2, input logic [W-1:0] w3,
                                        input logic [NW-2:0] node);
        btb_entry_pkg e;
        e.entry_way[0] = w0;
        e.entry_way[1] = w1;
        e.entry_way[2] = w2;
        e.entry_way[3] = w3;
        e.plru_node    = node;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [NW-1:0] wren,
                         input logic [IW-1:0] addr, input btb_entry_pkg wd);
        mem_req_vld   = vld;
        mem_req_wren  = wren;
        mem_req_addr  = addr;
        mem_req_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0);
    endtask

    // Reference model for the random phase.
    logic [W-1:0]    m_way  [NS][NW];
    logic [NW-2:0]   m_node [NS];

    initial begin
        btb_entry_pkg exp_e;
        btb_entry_pkg hold_e;
        btb_entry_pkg wd;

        rst = 1'b1;
        idle();
        repeat (3) step();
        check("rst_ack_vld",   256'(mem_ack_vld),   256'(1'b0));
        check("rst_init_done", 256'(init_done),     256'(1'b0));
        check("rst_rdata",     256'(mem_ack_rdata), 256'(0));

        // Clear walk; a request in the middle of it must be dropped.
        rst = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            if (c == 100) drive(1'b1, '0, 8'h00, '0);
            step();
            if (c == 100) begin
                check("init_drop_vld",  256'(mem_ack_vld), 256'(1'b0));
                check("init_drop_done", 256'(init_done),   256'(1'b0));
                idle();
            end
            if (c == 255) check("init_done_255", 256'(init_done), 256'(1'b0));
        end
        check("init_done_256", 256'(init_done), 256'(1'b1));

        drive(1'b1, '0, 8'hFF, '0);
        step();
        check("rd_ff_vld",   256'(mem_ack_vld),   256'(1'b1));
        check("rd_ff_rdata", 256'(mem_ack_rdata), 256'(0));

        // Write set 0x12 ways 0 and 2; unwritten way fields carry junk.
        drive(1'b1, 4'b0101, 8'h12, mk(W0, JK, W2, JK, 3'b101));
        step();
        exp_e = mk(W0, '0, W2, '0, 3'b101);
        check("wr12_ack_vld",   256'(mem_ack_vld),   256'(1'b1));
        check("wr12_ack_rdata", 256'(mem_ack_rdata), 256'(exp_e));
        drive(1'b1, 4'b0000, 8'h12, mk(JK, JK, JK, JK, 3'b111));
        step();
        check("rd12_vld",   256'(mem_ack_vld),   256'(1'b1));
        check("rd12_rdata", 256'(mem_ack_rdata), 256'(exp_e));

        // Partial write of way 1 only; node overwritten.
        drive(1'b1, 4'b0010, 8'h12, mk(JK, W1, JK, JK, 3'b010));
        step();
        exp_e = mk(W0, W1, W2, '0, 3'b010);
        check("part12_vld",   256'(mem_ack_vld),   256'(1'b1));
        check("part12_rdata", 256'(mem_ack_rdata), 256'(exp_e));

        // Back-to-back write/read of 0x40, then an idle hold cycle.
        drive(1'b1, 4'b1111, 8'h40, mk(W3, W2, W1, W0, 3'b011));
        step();
        drive(1'b1, 4'b0000, 8'h40, '0);
        step();
        exp_e = mk(W3, W2, W1, W0, 3'b011);
        check("b2b_rd_vld",   256'(mem_ack_vld),   256'(1'b1));
        check("b2b_rd_rdata", 256'(mem_ack_rdata), 256'(exp_e));
        idle();
        step();
        check("hold_vld",   256'(mem_ack_vld),   256'(1'b0));
        check("hold_rdata", 256'(mem_ack_rdata), 256'(exp_e));

        // Reset in the cycle the write ack is visible.
        drive(1'b1, 4'b1111, 8'h07, mk(W0, W1, W2, W3, 3'b111));
        step();
        check("wr07_vld", 256'(mem_ack_vld), 256'(1'b1));
        idle();
        rst = 1'b1;
        step();
        check("midrst_vld",   256'(mem_ack_vld),   256'(1'b0));
        check("midrst_done",  256'(init_done),     256'(1'b0));
        check("midrst_rdata", 256'(mem_ack_rdata), 256'(0));
        rst = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            step();
            if (c == 255) check("reinit_done_255", 256'(init_done), 256'(1'b0));
        end
        check("reinit_done_256", 256'(init_done), 256'(1'b1));
        drive(1'b1, 4'b0000, 8'h07, '0);
        step();
        check("rd07_vld",   256'(mem_ack_vld),   256'(1'b1));
        check("rd07_rdata", 256'(mem_ack_rdata), 256'(0));
        idle();

        // Random stream against the model, starting from the cleared array.
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) m_way[s][w] = '0;
            m_node[s] = '0;
        end
        hold_e = '0;
        for (int i = 0; i < 10000; i++) begin
            logic          vld;
            logic [NW-1:0] wren;
            logic [IW-1:0] addr;
            logic [63:0]   r;
            vld  = ($urandom_range(0, 3) != 0);
            wren = ($urandom_range(0, 1) == 0) ? '0 : NW'($urandom());
            addr = ((i % 8) == 0) ? IW'($urandom_range(0, NS - 1)) : IW'($urandom_range(0, 15));
            for (int w = 0; w < NW; w++) begin
                r = {$urandom(), $urandom()};
                wd.entry_way[w] = r[W-1:0];
            end
            wd.plru_node = (NW-1)'($urandom());
            if (vld) begin
                for (int w = 0; w < NW; w++) begin
                    if (wren[w]) m_way[addr][w] = wd.entry_way[w];
                    exp_e.entry_way[w] = m_way[addr][w];
                end
                if (|wren) m_node[addr] = wd.plru_node;
                exp_e.plru_node = m_node[addr];
                hold_e = exp_e;
            end
            drive(vld, wren, addr, wd);
            step();
            check("rnd_vld",   256'(mem_ack_vld),   256'(vld));
            check("rnd_rdata", 256'(mem_ack_rdata), 256'(hold_e));
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
